wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Write-side producer for the integer register file's single write port.
- Merges two result streams into one registered write per cycle:
  - in-order single-cycle pipe results;
  - long-latency results (load/mul-div) through a small FIFO.
- Keeps a pending-write scoreboard so decode can stall on operands or destinations not yet written back.

Parameters:
- FIFO_DEPTH, 4, long-latency result FIFO entries (power of 2, >=2)
- FIFO_AW, 2, log2(FIFO_DEPTH)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pipe_valid  in  1  pipe result present this cycle (no backpressure)
- pipe_addr  in  5  pipe destination register
- pipe_data  in  32  pipe result
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  arbiter accepts long-latency result
- lu_addr  in  5  long-latency destination register
- lu_data  in  32  long-latency result
- mark_valid  in  1  issue of long-latency op; sets scoreboard
- mark_addr  in  5  destination being marked
- r1addr  in  5  decode source 1 register
- r2addr  in  5  decode source 2 register
- dst_addr  in  5  decode destination register (WAW check)
- r1busy  out  1  source 1 has pending write
- r2busy  out  1  source 2 has pending write
- dstbusy  out  1  destination has pending write
- waddr  out  5  register-file write address
- wdata  out  32  register-file write data
- wvalid  out  1  register-file write enable

Behaviour:
- Reset is synchronous and active-high: `rst`=1 at a `clk` rising edge resets state. Clock and reset ports are named `clk` and `rst`.
- Reset state, including reset mid-operation:
  - waddr=0, wdata=0, wvalid=0;
  - FIFO emptied; in-flight entries are discarded;
  - all scoreboard bits cleared;
  - lu_ready=0 while rst is high.
- Write outputs are registered. Selection in each cycle, in priority order:
  1. pipe_valid=1: pipe result is written. Latency is 1 cycle.
  2. Otherwise, if the FIFO is non-empty: the FIFO head is written and popped.
  3. Otherwise: nothing is written (but see WB_BYPASS_EN).
  - If nothing is selected, wvalid=0 and waddr/wdata hold their previous values.
- Pipe results are never stalled. A long-latency result may wait indefinitely while pipe_valid stays high. The pipe is expected to leave gaps.
- lu handshake:
  - Transfer occurs when lu_valid & lu_ready.
  - lu_ready = !full. It is a function of registered FIFO count only; it does not depend on lu_valid.
  - A push and a pop in the same cycle leave the count unchanged.
  - Full: lu_ready=0. Empty: no pop.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is FIFO_AW+1 bits wide.
- Destination x0:
  - A selected write with addr 0 still consumes its slot (pops the FIFO);
  - wvalid stays 0 for that write;
  - the scoreboard is not touched.
- Scoreboard (31 bits, x1..x31; x0 is always 0):
  - Set bit mark_addr when mark_valid & mark_addr!=0.
  - Clear bit addr when a long-latency result is written (wvalid=1 on the registered output).
  - Pipe writes never clear bits.
  - Set and clear of the same bit in the same cycle: set wins. The clear belongs to the older op.
- Busy outputs are combinational:
  - rNbusy = pending[rNaddr] & !(wvalid & waddr==rNaddr & source==long-latency).
  - Same rule for dstbusy with dst_addr.
  - A result being written this cycle is not busy, because the regfile forwards same-cycle writes.
- Decode stalls on dstbusy, so a second mark of a pending register does not occur. If it does occur, the bit simply stays set.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when pipe_valid=0, the FIFO is empty and lu_valid=1, the lu result is written directly in the same selection cycle without entering the FIFO. Minimum long-latency latency is 1 cycle.
- Undefined: every lu result enters the FIFO first. Minimum latency is 2 cycles (push, then pop to output).
- Port list is identical either way.

Test Plan:
- Reset, then pipe_valid=1 with addr=5, data=0x1234 -> next cycle wvalid=1, waddr=5, wdata=0x1234. With `rst` asserted mid-stream -> all outputs 0 next cycle.
- mark x7, then lu result x7=0xDEADBEEF with pipe idle:
  - r1addr=7 -> r1busy=1 until the write cycle; 0 from the write cycle onward;
  - write seen after 2 cycles (1 with WB_BYPASS_EN).
- pipe_valid held high 6 cycles while 5 lu results are offered, FIFO_DEPTH=4:
  - lu_ready drops after 4 accepts;
  - once the pipe idles, the FIFO drains in order, one write per cycle, with no loss or duplication.
- Same-cycle mark x3 and long-latency write-back of x3 -> pending[3] stays 1 afterwards.
- lu result to x0 with data 0xFFFFFFFF -> FIFO pops, wvalid stays 0, no busy change.
- Fill FIFO, reset mid-drain -> lu_ready=0 during reset, then 1; FIFO empty; scoreboard clear; no stale writes after reset.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: merges in-order pipe results with FIFO-buffered
// long-latency results and tracks pending writes. Optional macro: WB_BYPASS_EN.
module wb_write_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  input  logic        mark_valid,
  input  logic [4:0]  mark_addr,
  input  logic [4:0]  r1addr,
  input  logic [4:0]  r2addr,
  input  logic [4:0]  dst_addr,
  output logic        r1busy,
  output logic        r2busy,
  output logic        dstbusy,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        wvalid
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {SEL_NONE, SEL_PIPE, SEL_FIFO, SEL_BYP} sel_e;

  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  entry_t             mem_q [FIFO_DEPTH];
  entry_t             mem_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [4:0]         waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               wvalid_q, wvalid_d;
  logic               lu_wr_q, lu_wr_d;
  logic [31:0]        pending_q, pending_d;

  sel_e        sel;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic        push, pop;
  logic        lu_write_now;

  always_comb begin
    lu_ready = !rst && (count_q != CNT_FULL);

    sel      = SEL_NONE;
    sel_addr = '0;
    sel_data = '0;
    if (pipe_valid) begin
      sel      = SEL_PIPE;
      sel_addr = pipe_addr;
      sel_data = pipe_data;
    end else if (count_q != '0) begin
      sel      = SEL_FIFO;
      sel_addr = mem_q[rd_ptr_q].addr;
      sel_data = mem_q[rd_ptr_q].data;
    end
`ifdef WB_BYPASS_EN
    else if (lu_valid && lu_ready) begin
      sel      = SEL_BYP;
      sel_addr = lu_addr;
      sel_data = lu_data;
    end
`endif

    // A bypassed result is consumed directly and never occupies a FIFO slot.
    push = lu_valid && lu_ready && (sel != SEL_BYP);
    pop  = (sel == SEL_FIFO);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{addr: lu_addr, data: lu_data};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wvalid_d = 1'b0;
    lu_wr_d  = 1'b0;
    if (sel != SEL_NONE) begin
      waddr_d  = sel_addr;
      wdata_d  = sel_data;
      wvalid_d = (sel_addr != '0);
      lu_wr_d  = (sel != SEL_PIPE) && (sel_addr != '0);
    end

    // Clear applies first so a same-cycle mark from a newer op wins.
    lu_write_now = wvalid_q && lu_wr_q;
    pending_d    = pending_q;
    if (lu_write_now) begin
      pending_d[waddr_q] = 1'b0;
    end
    if (mark_valid && (mark_addr != '0)) begin
      pending_d[mark_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;

    r1busy  = pending_q[r1addr]   && !(lu_write_now && (waddr_q == r1addr));
    r2busy  = pending_q[r2addr]   && !(lu_write_now && (waddr_q == r2addr));
    dstbusy = pending_q[dst_addr] && !(lu_write_now && (waddr_q == dst_addr));

    waddr  = waddr_q;
    wdata  = wdata_q;
    wvalid = wvalid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wvalid_q  <= 1'b0;
      lu_wr_q   <= 1'b0;
      pending_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wvalid_q  <= wvalid_d;
      lu_wr_q   <= lu_wr_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (FIFO_DEPTH=4); follows WB_BYPASS_EN
// for the long-latency write latency.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        mark_valid;
  logic [4:0]  mark_addr;
  logic [4:0]  r1addr, r2addr, dst_addr;
  logic        r1busy, r2busy, dstbusy;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wvalid;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  wb_write_arbiter #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .mark_valid(mark_valid), .mark_addr(mark_addr),
    .r1addr(r1addr), .r2addr(r2addr), .dst_addr(dst_addr),
    .r1busy(r1busy), .r2busy(r2busy), .dstbusy(dstbusy),
    .waddr(waddr), .wdata(wdata), .wvalid(wvalid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance past the next rising edge; registered outputs are then stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; pipe_valid = 1'b0; pipe_addr = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    mark_valid = 1'b0; mark_addr = '0;
    r1addr = '0; r2addr = '0; dst_addr = '0;
  endtask

  task automatic check_write(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_wvalid"}, {31'b0, wvalid}, 32'd1);
    check({tag, "_waddr"}, {27'b0, waddr}, {27'b0, a});
    check({tag, "_wdata"}, wdata, d);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    check("rst_wvalid", {31'b0, wvalid}, 32'd0);
    check("rst_waddr", {27'b0, waddr}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_lu_ready", {31'b0, lu_ready}, 32'd0);
    rst = 1'b0; settle();
    check("post_rst_lu_ready", {31'b0, lu_ready}, 32'd1);

    // Pipe write, then reset mid-stream.
    pipe_valid = 1'b1; pipe_addr = 5'd5; pipe_data = 32'h1234;
    tick();
    check_write("pipe1", 5'd5, 32'h1234);
    pipe_addr = 5'd6; pipe_data = 32'h55; rst = 1'b1;
    tick();
    check("midrst_wvalid", {31'b0, wvalid}, 32'd0);
    check("midrst_waddr", {27'b0, waddr}, 32'd0);
    check("midrst_wdata", wdata, 32'd0);
    idle(); tick();
    check("idle_wvalid", {31'b0, wvalid}, 32'd0);

    // Mark x7, then a long-latency result for x7.
    mark_valid = 1'b1; mark_addr = 5'd7;
    r1addr = 5'd7; r2addr = 5'd7; dst_addr = 5'd7;
    tick();
    mark_valid = 1'b0; settle();
    check("x7_r1busy_marked", {31'b0, r1busy}, 32'd1);
    check("x7_r2busy_marked", {31'b0, r2busy}, 32'd1);
    check("x7_dstbusy_marked", {31'b0, dstbusy}, 32'd1);
    lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'hDEADBEEF;
    settle();
    check("x7_lu_ready", {31'b0, lu_ready}, 32'd1);
    tick();
    lu_valid = 1'b0;
`ifndef WB_BYPASS_EN
    settle();
    check("x7_queued_wvalid", {31'b0, wvalid}, 32'd0);
    check("x7_queued_r1busy", {31'b0, r1busy}, 32'd1);
    tick();
`endif
    check_write("x7", 5'd7, 32'hDEADBEEF);
    check("x7_wcycle_r1busy", {31'b0, r1busy}, 32'd0);
    check("x7_wcycle_dstbusy", {31'b0, dstbusy}, 32'd0);
    tick();
    check("x7_after_wvalid", {31'b0, wvalid}, 32'd0);
    check("x7_after_r1busy", {31'b0, r1busy}, 32'd0);
    idle();

    // Pipe busy 6 cycles while 5 lu results are offered; FIFO holds 4.
    for (int k = 0; k < 6; k++) begin
      pipe_valid = 1'b1; pipe_addr = 5'(10 + k); pipe_data = 32'(32'h100 + k);
      lu_valid = 1'b1;
      lu_addr = (k < 4) ? 5'(20 + k) : 5'd24;
      lu_data = (k < 4) ? 32'(32'hA0 + k) : 32'hA4;
      settle();
      check($sformatf("burst%0d_lu_ready", k), {31'b0, lu_ready}, (k < 4) ? 32'd1 : 32'd0);
      tick();
      check_write($sformatf("burst%0d_pipe", k), 5'(10 + k), 32'(32'h100 + k));
    end
    pipe_valid = 1'b0; settle();
    check("drain_full_lu_ready", {31'b0, lu_ready}, 32'd0);
    tick();
    check_write("drain0", 5'd20, 32'hA0);
    check("drain_lu_ready", {31'b0, lu_ready}, 32'd1);
    tick();
    lu_valid = 1'b0;
    check_write("drain1", 5'd21, 32'hA1);
    tick();
    check_write("drain2", 5'd22, 32'hA2);
    tick();
    check_write("drain3", 5'd23, 32'hA3);
    tick();
    check_write("drain4", 5'd24, 32'hA4);
    tick();
    check("drain_done_wvalid", {31'b0, wvalid}, 32'd0);
    idle();

    // Re-mark of x3 in the same cycle its long-latency write retires.
    mark_valid = 1'b1; mark_addr = 5'd3; r1addr = 5'd3;
    tick();
    mark_valid = 1'b0;
    lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'h33;
    tick();
    lu_valid = 1'b0;
`ifndef WB_BYPASS_EN
    tick();
`endif
    check_write("x3", 5'd3, 32'h33);
    mark_valid = 1'b1; mark_addr = 5'd3;
    tick();
    mark_valid = 1'b0; settle();
    check("x3_set_wins_r1busy", {31'b0, r1busy}, 32'd1);

    // Long-latency result to x0: slot consumed, no write, no busy change.
    lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'hFFFFFFFF; dst_addr = 5'd0;
    settle();
    check("x0_dstbusy", {31'b0, dstbusy}, 32'd0);
    tick();
    lu_valid = 1'b0;
`ifndef WB_BYPASS_EN
    check("x0_queued_wvalid", {31'b0, wvalid}, 32'd0);
    tick();
`endif
    check("x0_pop_wvalid", {31'b0, wvalid}, 32'd0);
    check("x0_r1busy", {31'b0, r1busy}, 32'd1);
    lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h99;
    tick();
    lu_valid = 1'b0;
`ifndef WB_BYPASS_EN
    tick();
`endif
    check_write("after_x0", 5'd9, 32'h99);
    idle();

    // Fill the FIFO, then reset mid-drain.
    mark_valid = 1'b1; mark_addr = 5'd12;
    tick();
    mark_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pipe_valid = 1'b1; pipe_addr = 5'd1; pipe_data = 32'(k);
      lu_valid = 1'b1; lu_addr = 5'(16 + k); lu_data = 32'(32'hB0 + k);
      tick();
    end
    idle(); settle();
    check("fill_lu_ready", {31'b0, lu_ready}, 32'd0);
    tick();
    check_write("fill_drain0", 5'd16, 32'hB0);
    rst = 1'b1; lu_valid = 1'b1; lu_addr = 5'd2; lu_data = 32'h22;
    settle();
    check("rst2_lu_ready", {31'b0, lu_ready}, 32'd0);
    tick();
    check("rst2_wvalid", {31'b0, wvalid}, 32'd0);
    check("rst2_waddr", {27'b0, waddr}, 32'd0);
    idle(); r1addr = 5'd12; r2addr = 5'd3; settle();
    check("rst2_lu_ready_after", {31'b0, lu_ready}, 32'd1);
    check("rst2_r1busy", {31'b0, r1busy}, 32'd0);
    check("rst2_r2busy", {31'b0, r2busy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rst2_stale%0d", k), {31'b0, wvalid}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
